countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: reset is sampled only on the rising edge of clk.
REQ-002 The block SHALL have no parameters; it is fixed to a BCD MM:SS countdown with a maximum of 59:59.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 tick  input  1  one-cycle 1 Hz enable pulse; one pulse means one second has elapsed.
REQ-006 start  input  1  level sampled each cycle; requests run/resume.
REQ-007 stop  input  1  level sampled each cycle; requests pause, or clear/acknowledge when expired.
REQ-008 set  input  1  load request for set_min_T, set_min_U, set_sec_T, set_sec_U.
REQ-009 set_min_T  input  3  minutes tens digit to load, valid 0-5.
REQ-010 set_min_U  input  4  minutes units digit to load, valid 0-9.
REQ-011 set_sec_T  input  3  seconds tens digit to load, valid 0-5.
REQ-012 set_sec_U  input  4  seconds units digit to load, valid 0-9.
REQ-013 min_T, min_U, sec_T, sec_U  output  3/4/3/4  current count digits, registered.
REQ-014 running  output  1  high in RUN state only.
REQ-015 expired  output  1  high in EXPIRED state only.
REQ-016 expired_pulse  output  1  one-cycle pulse on entry to EXPIRED.
REQ-017 set_err  output  1  one-cycle pulse when a set request is rejected as invalid.

Function
REQ-018 The block SHALL have four states: IDLE, RUN, PAUSED, EXPIRED.
REQ-019 Input priority SHALL be reset > set > stop > start > tick.
REQ-020 A set SHALL be accepted only if every set digit is in range; an accepted set loads all four digits, clears the fault/expiry, and enters IDLE from any state.
REQ-021 A rejected set SHALL leave the count and state unchanged and pulse set_err for 1 cycle.
REQ-022 start in IDLE or PAUSED SHALL enter RUN next cycle, but only if the count is not 00:00; otherwise it is ignored.
REQ-023 start in RUN or EXPIRED SHALL have no effect.
REQ-024 stop in RUN SHALL enter PAUSED; stop in EXPIRED SHALL enter IDLE with the count held at 00:00; stop in IDLE or PAUSED SHALL have no effect.
REQ-025 If start and stop are asserted in the same cycle, stop SHALL win.
REQ-026 tick in RUN SHALL decrement the count by exactly one second on that edge; tick in any other state SHALL be ignored.
REQ-027 The decrement borrow chain SHALL be:
- sec_U 0 -> 9 with a borrow from sec_T;
- sec_T 0 -> 5 with a borrow from min_U;
- min_U 0 -> 9 with a borrow from min_T;
- min_T only decrements on a borrow and never underflows.
REQ-028 A tick in RUN with the count at 00:01 SHALL produce 00:00 and enter EXPIRED on the same edge, with expired_pulse high for exactly the following cycle.
REQ-029 The count SHALL never wrap below 00:00; there is no decrement in EXPIRED.
REQ-030 A tick coincident with stop in RUN SHALL NOT decrement; the block pauses with the count unchanged.
REQ-031 A tick coincident with an accepted set SHALL NOT decrement; the loaded value appears unmodified.
REQ-032 All outputs SHALL be registered, with a latency of 1 cycle from the causing input edge.

Reset
REQ-033 On reset the block SHALL enter IDLE and drive all digits to 0, running=0, expired=0, expired_pulse=0, set_err=0.
REQ-034 Reset SHALL take effect mid-RUN or in EXPIRED with no residual pulse on the cycle after reset.
REQ-035 Reset SHALL override any coincident set, start, stop or tick.

Verification
REQ-036 Borrow chain: set 10:00, start, 1 tick -> 09:59; a further 599 ticks -> 00:00, expired=1, expired_pulse exactly 1 cycle.
REQ-037 Pause/resume: set 00:05, start, 2 ticks -> 00:03; stop+tick same cycle -> 00:03 PAUSED; ticks ignored; start, 3 ticks -> EXPIRED.
REQ-038 Invalid set: in RUN at 01:30, set with sec_T=6 -> set_err 1 cycle, count 01:30, running=1 unchanged.
REQ-039 Zero start: after reset, start -> state stays IDLE, running=0; stop in EXPIRED -> IDLE, expired=0, count 00:00.
REQ-040 Reset mid-run: at 59:59 RUN with tick, reset asserted -> next cycle 00:00 IDLE, all flags 0.
REQ-041 Simultaneous: start+stop in PAUSED -> stays PAUSED; set 00:01 + tick in RUN -> 00:01 IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer (max 59:59) with IDLE/RUN/PAUSED/EXPIRED control.
// Every output is registered and updates on the clock edge after its cause.
module countdown_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       stop,
   input  logic       set,
   input  logic [2:0] set_min_T,
   input  logic [3:0] set_min_U,
   input  logic [2:0] set_sec_T,
   input  logic [3:0] set_sec_U,
   output logic [2:0] min_T,
   output logic [3:0] min_U,
   output logic [2:0] sec_T,
   output logic [3:0] sec_U,
   output logic       running,
   output logic       expired,
   output logic       expired_pulse,
   output logic       set_err
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t     state_reg;
   logic       set_valid;
   logic       count_zero;
   logic       count_one;
   logic [2:0] dec_min_T;
   logic [3:0] dec_min_U;
   logic [2:0] dec_sec_T;
   logic [3:0] dec_sec_U;

   assign set_valid  = (set_min_T <= 3'd5) && (set_min_U <= 4'd9) &&
                       (set_sec_T <= 3'd5) && (set_sec_U <= 4'd9);
   assign count_zero = (min_T == 3'd0) && (min_U == 4'd0) &&
                       (sec_T == 3'd0) && (sec_U == 4'd0);
   assign count_one  = (min_T == 3'd0) && (min_U == 4'd0) &&
                       (sec_T == 3'd0) && (sec_U == 4'd1);

   // Borrow chain; only used when the count is non-zero, so min_T never underflows.
   always_comb begin
      dec_min_T = min_T;
      dec_min_U = min_U;
      dec_sec_T = sec_T;
      dec_sec_U = sec_U;
      if (sec_U != 4'd0) begin
         dec_sec_U = sec_U - 4'd1;
      end else begin
         dec_sec_U = 4'd9;
         if (sec_T != 3'd0) begin
            dec_sec_T = sec_T - 3'd1;
         end else begin
            dec_sec_T = 3'd5;
            if (min_U != 4'd0) begin
               dec_min_U = min_U - 4'd1;
            end else begin
               dec_min_U = 4'd9;
               if (min_T != 3'd0) dec_min_T = min_T - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         min_T         <= 3'd0;
         min_U         <= 4'd0;
         sec_T         <= 3'd0;
         sec_U         <= 4'd0;
         running       <= 1'b0;
         expired       <= 1'b0;
         expired_pulse <= 1'b0;
         set_err       <= 1'b0;
      end else begin
         expired_pulse <= 1'b0;
         set_err       <= 1'b0;
         if (set) begin
            // A rejected set consumes the cycle: nothing else is acted on.
            if (set_valid) begin
               min_T     <= set_min_T;
               min_U     <= set_min_U;
               sec_T     <= set_sec_T;
               sec_U     <= set_sec_U;
               state_reg <= IDLE;
               running   <= 1'b0;
               expired   <= 1'b0;
            end else begin
               set_err <= 1'b1;
            end
         end else if (stop) begin
            case (state_reg)
               RUN: begin
                  state_reg <= PAUSED;
                  running   <= 1'b0;
               end
               EXPIRED: begin
                  state_reg <= IDLE;
                  expired   <= 1'b0;
               end
               default: ;
            endcase
         end else if (start) begin
            if ((state_reg == IDLE || state_reg == PAUSED) && !count_zero) begin
               state_reg <= RUN;
               running   <= 1'b1;
            end
         end else if (tick && state_reg == RUN && !count_zero) begin
            min_T <= dec_min_T;
            min_U <= dec_min_U;
            sec_T <= dec_sec_T;
            sec_U <= dec_sec_U;
            if (count_one) begin
               state_reg     <= EXPIRED;
               running       <= 1'b0;
               expired       <= 1'b1;
               expired_pulse <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one task per scenario, inline checks
// against hand-computed MM:SS values and flag states.
module tb_countdown_timer;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       start;
   logic       stop;
   logic       set;
   logic [2:0] set_min_T;
   logic [3:0] set_min_U;
   logic [2:0] set_sec_T;
   logic [3:0] set_sec_U;
   logic [2:0] min_T;
   logic [3:0] min_U;
   logic [2:0] sec_T;
   logic [3:0] sec_U;
   logic       running;
   logic       expired;
   logic       expired_pulse;
   logic       set_err;

   logic [13:0] count;
   int          n_checks;
   int          n_fail;

   assign count = {min_T, min_U, sec_T, sec_U};

   countdown_timer dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .start        (start),
      .stop         (stop),
      .set          (set),
      .set_min_T    (set_min_T),
      .set_min_U    (set_min_U),
      .set_sec_T    (set_sec_T),
      .set_sec_U    (set_sec_U),
      .min_T        (min_T),
      .min_U        (min_U),
      .sec_T        (sec_T),
      .sec_U        (sec_U),
      .running      (running),
      .expired      (expired),
      .expired_pulse(expired_pulse),
      .set_err      (set_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_set(input logic [2:0] mt, input logic [3:0] mu,
                         input logic [2:0] st, input logic [3:0] su);
      set = 1'b1; set_min_T = mt; set_min_U = mu; set_sec_T = st; set_sec_U = su;
      cyc();
      set = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_checks++;
      if (count !== 14'd0) begin
         n_fail++; $display("FAIL reset_count: got %h required 0000", count);
      end
      n_checks++;
      if ({running, expired, expired_pulse, set_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b required 0000",
                            {running, expired, expired_pulse, set_err});
      end
      $display("test_reset done");
   endtask

   task automatic test_zero_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_checks++;
      if (running !== 1'b0 || count !== 14'd0) begin
         n_fail++; $display("FAIL zero_start: running=%b count=%h required 0/0000", running, count);
      end
      $display("test_zero_start done");
   endtask

   task automatic test_borrow_chain();
      do_set(3'd1, 4'd0, 3'd0, 4'd0);
      n_checks++;
      if (count !== {3'd1, 4'd0, 3'd0, 4'd0} || running !== 1'b0) begin
         n_fail++; $display("FAIL set_10_00: count=%h running=%b required 1000/0", count, running);
      end
      start = 1'b1; cyc(); start = 1'b0;
      n_checks++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL start_run: running=%b required 1", running);
      end
      tick = 1'b1; cyc(); tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd9, 3'd5, 4'd9}) begin
         n_fail++; $display("FAIL borrow_09_59: got %h required 0959", count);
      end
      tick = 1'b1; repeat (598) cyc(); tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd0, 3'd0, 4'd1} || running !== 1'b1 || expired !== 1'b0) begin
         n_fail++; $display("FAIL at_00_01: count=%h running=%b expired=%b required 0001/1/0",
                            count, running, expired);
      end
      tick = 1'b1; cyc(); tick = 1'b0;
      n_checks++;
      if (count !== 14'd0 || expired !== 1'b1 || expired_pulse !== 1'b1 || running !== 1'b0) begin
         n_fail++; $display("FAIL expire: count=%h exp=%b pulse=%b run=%b required 0000/1/1/0",
                            count, expired, expired_pulse, running);
      end
      tick = 1'b1; cyc(); tick = 1'b0;
      n_checks++;
      if (count !== 14'd0 || expired !== 1'b1 || expired_pulse !== 1'b0) begin
         n_fail++; $display("FAIL pulse_one_cycle: count=%h exp=%b pulse=%b required 0000/1/0",
                            count, expired, expired_pulse);
      end
      start = 1'b1; cyc(); start = 1'b0;
      n_checks++;
      if (expired !== 1'b1 || running !== 1'b0) begin
         n_fail++; $display("FAIL start_in_expired: exp=%b run=%b required 1/0", expired, running);
      end
      stop = 1'b1; cyc(); stop = 1'b0;
      n_checks++;
      if (expired !== 1'b0 || running !== 1'b0 || count !== 14'd0) begin
         n_fail++; $display("FAIL stop_in_expired: exp=%b run=%b count=%h required 0/0/0000",
                            expired, running, count);
      end
      $display("test_borrow_chain done");
   endtask

   task automatic test_pause_resume();
      do_set(3'd0, 4'd0, 3'd0, 4'd5);
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; repeat (2) cyc(); tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd0, 3'd0, 4'd3} || running !== 1'b1) begin
         n_fail++; $display("FAIL run_00_03: count=%h run=%b required 0003/1", count, running);
      end
      stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd0, 3'd0, 4'd3} || running !== 1'b0) begin
         n_fail++; $display("FAIL stop_tick: count=%h run=%b required 0003/0", count, running);
      end
      tick = 1'b1; repeat (3) cyc(); tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd0, 3'd0, 4'd3} || running !== 1'b0) begin
         n_fail++; $display("FAIL paused_ticks: count=%h run=%b required 0003/0", count, running);
      end
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL start_stop_paused: run=%b required 0", running);
      end
      start = 1'b1; cyc(); start = 1'b0;
      n_checks++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL resume: run=%b required 1", running);
      end
      tick = 1'b1; repeat (3) cyc(); tick = 1'b0;
      n_checks++;
      if (count !== 14'd0 || expired !== 1'b1 || expired_pulse !== 1'b1) begin
         n_fail++; $display("FAIL resume_expire: count=%h exp=%b pulse=%b required 0000/1/1",
                            count, expired, expired_pulse);
      end
      $display("test_pause_resume done");
   endtask

   task automatic test_invalid_set();
      do_set(3'd0, 4'd1, 3'd3, 4'd0);
      start = 1'b1; cyc(); start = 1'b0;
      do_set(3'd0, 4'd1, 3'd6, 4'd0);
      n_checks++;
      if (set_err !== 1'b1 || count !== {3'd0, 4'd1, 3'd3, 4'd0} || running !== 1'b1) begin
         n_fail++; $display("FAIL invalid_set: err=%b count=%h run=%b required 1/0130/1",
                            set_err, count, running);
      end
      cyc();
      n_checks++;
      if (set_err !== 1'b0) begin
         n_fail++; $display("FAIL set_err_one_cycle: err=%b required 0", set_err);
      end
      do_set(3'd0, 4'd10, 3'd0, 4'd0);
      n_checks++;
      if (set_err !== 1'b1 || count !== {3'd0, 4'd1, 3'd3, 4'd0}) begin
         n_fail++; $display("FAIL invalid_min_u: err=%b count=%h required 1/0130", set_err, count);
      end
      $display("test_invalid_set done");
   endtask

   task automatic test_set_tick();
      tick = 1'b1;
      do_set(3'd0, 4'd0, 3'd0, 4'd1);
      tick = 1'b0;
      n_checks++;
      if (count !== {3'd0, 4'd0, 3'd0, 4'd1} || running !== 1'b0 || set_err !== 1'b0) begin
         n_fail++; $display("FAIL set_with_tick: count=%h run=%b err=%b required 0001/0/0",
                            count, running, set_err);
      end
      $display("test_set_tick done");
   endtask

   task automatic test_reset_mid_run();
      do_set(3'd5, 4'd9, 3'd5, 4'd9);
      start = 1'b1; cyc(); start = 1'b0;
      reset = 1'b1; tick = 1'b1; start = 1'b1; cyc();
      reset = 1'b0; tick = 1'b0; start = 1'b0;
      n_checks++;
      if (count !== 14'd0 || {running, expired, expired_pulse, set_err} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_mid_run: count=%h flags=%b required 0000/0000",
                            count, {running, expired, expired_pulse, set_err});
      end
      do_set(3'd0, 4'd0, 3'd0, 4'd1);
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; cyc(); tick = 1'b0;
      reset = 1'b1; cyc(); reset = 1'b0;
      n_checks++;
      if (expired_pulse !== 1'b0 || expired !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_expired: pulse=%b exp=%b required 0/0",
                            expired_pulse, expired);
      end
      $display("test_reset_mid_run done");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; set = 1'b0;
      set_min_T = 3'd0; set_min_U = 4'd0; set_sec_T = 3'd0; set_sec_U = 4'd0;
      cyc();
      test_reset();
      test_zero_start();
      test_borrow_chain();
      test_pause_resume();
      test_invalid_set();
      test_set_tick();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
